// File: rtl/uart_baud_gen_if.sv
// Configuration and strobe bundle between the UART paths and the baud-rate generator.
interface uart_baud_gen_if #(
  parameter int DIV_W  = 13,
  parameter int FRAC_W = 4
);
  logic              en;
  logic [DIV_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              rx_resync;
  logic              baud_tick;
  logic              xmit_pulse;
  logic              rx_sample;

  modport master (
    output en, baud_val, baud_frac, rx_resync,
    input  baud_tick, xmit_pulse, rx_sample
  );

  modport slave (
    input  en, baud_val, baud_frac, rx_resync,
    output baud_tick, xmit_pulse, rx_sample
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate divider producing an oversampling tick, a tx bit pulse and an
// rx mid-bit sample strobe with start-bit resynchronisation.
module uart_baud_gen #(
  parameter int DIV_W  = 13,
  parameter int FRAC_W = 4,
  parameter int OVS_W  = 4
) (
  input  logic           i_clk_sys,
  input  logic           i_rst_sys,
  uart_baud_gen_if.slave bus
);
  localparam int              OVS     = 1 << OVS_W;
  localparam logic [OVS_W-1:0] TX_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] RX_MID  = OVS_W'(OVS / 2 - 1);

  logic [DIV_W:0]    r_div_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_tick;
  logic [OVS_W-1:0]  r_tx_cnt;
  logic [OVS_W-1:0]  r_rx_cnt;

  logic [FRAC_W:0]   w_acc_sum;
  logic [DIV_W:0]    w_reload;

  // Extra counter bit absorbs baud_val all-ones plus the fractional carry.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, bus.baud_frac};
  assign w_reload  = {1'b0, bus.baud_val} + {{DIV_W{1'b0}}, w_acc_sum[FRAC_W]};

  always_ff @(posedge i_clk_sys or posedge i_rst_sys) begin
    if (i_rst_sys) begin
      r_div_cnt <= '0;
      r_acc     <= '0;
      r_tick    <= 1'b0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
    end else if (!bus.en) begin
      r_div_cnt <= '0;
      r_acc     <= '0;
      r_tick    <= 1'b0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (r_div_cnt == '0) begin
        r_tick    <= 1'b1;
        r_acc     <= w_acc_sum[FRAC_W-1:0];
        r_div_cnt <= w_reload;
      end else begin
        r_tick    <= 1'b0;
        r_div_cnt <= r_div_cnt - (DIV_W + 1)'(1);
      end
      if (r_tick) r_tx_cnt <= r_tx_cnt + OVS_W'(1);
      // Resync wins over a coincident tick, which is then not counted.
      if (bus.rx_resync)  r_rx_cnt <= '0;
      else if (r_tick)    r_rx_cnt <= r_rx_cnt + OVS_W'(1);
    end
  end

  assign bus.baud_tick  = r_tick;
  assign bus.xmit_pulse = r_tick & (r_tx_cnt == TX_LAST);
  assign bus.rx_sample  = r_tick & (r_rx_cnt == RX_MID) & ~bus.rx_resync;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Randomised self-checking bench for uart_baud_gen against a tick-schedule reference model.
module tb_uart_baud_gen;
  localparam int DIV_W  = 13;
  localparam int FRAC_W = 4;
  localparam int OVS_W  = 4;
  localparam int OVS    = 1 << OVS_W;
  localparam int FSTEP  = 1 << FRAC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS_W(OVS_W)) dut (
    .i_clk_sys (clk),
    .i_rst_sys (rst),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: absolute edge index of the next tick, running fractional total,
  // tick counts since enable (tx) and since the last resync (rx).
  longint cyc    = 0;
  longint m_next = 0;
  longint m_fsum = 0;
  int     m_txi  = 0;
  int     m_rxi  = 0;
  bit     m_tick = 1'b0;
  bit     exp_tick, exp_x, exp_rx;

  task automatic model_clear();
    m_tick = 1'b0;
    m_fsum = 0;
    m_txi  = 0;
    m_rxi  = 0;
  endtask

  task automatic drive(input bit e, input int bv, input int bf, input bit rs);
    bus.en        = e;
    bus.baud_val  = DIV_W'(bv);
    bus.baud_frac = FRAC_W'(bf);
    bus.rx_resync = rs;
    exp_tick = m_tick;
    exp_x    = m_tick && (((m_txi + 1) % OVS) == 0);
    exp_rx   = m_tick && !rs && (((m_rxi + 1) % OVS) == OVS / 2);
    #1;
  endtask

  task automatic clk_edge();
    longint old, carry;
    @(posedge clk);
    #1;
    if (rst || !bus.en) begin
      model_clear();
      m_next = cyc + 1;
    end else begin
      if (bus.rx_resync) m_rxi = 0;
      else if (m_tick)   m_rxi++;
      if (m_tick) m_txi++;
      if (cyc == m_next) begin
        old    = m_fsum;
        m_fsum = m_fsum + longint'(bus.baud_frac);
        carry  = (m_fsum / FSTEP) - (old / FSTEP);
        m_next = cyc + longint'(bus.baud_val) + 1 + carry;
        m_tick = 1'b1;
      end else begin
        m_tick = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, 0, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== 3'b000) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%b exp=000", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample});
      end
      clk_edge();
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b0, 3, 0, 1'b0);
    clk_edge();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 3, 0, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_frac();
    longint tk[$];
    drive(1'b0, 4, 8, 1'b0);
    clk_edge();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 4, 8, 1'b0);
      if (bus.baud_tick) tk.push_back(cyc);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL frac cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
    n_vec++;
    if (tk.size() < 33) begin
      n_err++;
      $display("FAIL frac_count ticks=%0d need>=33", tk.size());
    end else if (tk[32] - tk[0] != 176 || tk[1] - tk[0] != 5 || tk[2] - tk[1] != 6) begin
      n_err++;
      $display("FAIL frac_span span32=%0d p1=%0d p2=%0d exp 176/5/6",
               tk[32] - tk[0], tk[1] - tk[0], tk[2] - tk[1]);
    end
  endtask

  task automatic test_min();
    drive(1'b0, 0, 0, 1'b0);
    clk_edge();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 0, 0, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL min cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_resync();
    bit rs, hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 29) == 0);
      if (i >= 150 && !hit && m_tick) begin
        rs  = 1'b1;
        hit = 1'b1;
      end
      drive(1'b1, 3, 0, rs);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL resync cyc=%0d rs=%0b got=%b exp=%b", cyc, rs,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_reconfig();
    drive(1'b0, 3, 0, 1'b0);
    clk_edge();
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, (i < 6) ? 3 : 9, 0, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL reconfig cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 60; i++) begin
      drive(!(i >= 30 && i < 33), 2, 5, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL enable cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_limits();
    longint tk[$];
    int bv, bf;
    bv = (1 << DIV_W) - 1;
    bf = FSTEP - 1;
    drive(1'b0, bv, bf, 1'b0);
    clk_edge();
    for (int i = 0; i < 3 * ((1 << DIV_W) + 1) + 5; i++) begin
      drive(1'b1, bv, bf, 1'b0);
      if (bus.baud_tick) tk.push_back(cyc);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL limits cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
    n_vec++;
    if (tk.size() < 4) begin
      n_err++;
      $display("FAIL limits_count ticks=%0d need>=4", tk.size());
    end else begin
      for (int k = 1; k < tk.size(); k++) begin
        if (tk[k] - tk[k-1] != (1 << DIV_W) && tk[k] - tk[k-1] != (1 << DIV_W) + 1) begin
          n_err++;
          $display("FAIL limits_period k=%0d period=%0d exp %0d or %0d", k,
                   tk[k] - tk[k-1], 1 << DIV_W, (1 << DIV_W) + 1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 0, 0, 1'b0);
      clk_edge();
    end
    drive(1'b1, 0, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    m_next = cyc;
    n_vec++;
    if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=000", {bus.baud_tick, bus.xmit_pulse, bus.rx_sample});
    end
    #1;
    rst = 1'b0;
    clk_edge();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1, 3, 1'b0);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  task automatic test_random();
    bit e, rs;
    int bv, bf;
    for (int i = 0; i < 3000; i++) begin
      e  = ($urandom_range(0, 39) != 0);
      bv = $urandom_range(0, 6);
      bf = $urandom_range(0, FSTEP - 1);
      rs = ($urandom_range(0, 19) == 0);
      drive(e, bv, bf, rs);
      n_vec++;
      if ({bus.baud_tick, bus.xmit_pulse, bus.rx_sample} !== {exp_tick, exp_x, exp_rx}) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                 {bus.baud_tick, bus.xmit_pulse, bus.rx_sample}, {exp_tick, exp_x, exp_rx});
      end
      clk_edge();
    end
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.baud_val  = '0;
    bus.baud_frac = '0;
    bus.rx_resync = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_frac();
    test_min();
    test_resync();
    test_reconfig();
    test_enable();
    test_limits();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud-rate generator for the UART transmit/receive paths in the serial channel controller. It divides `clk_sys` by a programmable integer-plus-fractional divisor to produce an oversampling tick. From that tick it derives a transmit bit pulse and a receive mid-bit sample strobe. The receive phase can be resynchronised to a detected start-bit edge. It replaces the fixed 9-bit, integer-only, 16x divider and adds an enable input, fractional division, configurable oversampling and an rx sample-point output.

## Interface
- `DIV_W`, 13, width of the integer divisor `baud_val`.
- `FRAC_W`, 4, width of the fractional divisor `baud_frac`; the fractional step is 1/2^FRAC_W.
- `OVS_W`, 4, log2 of the oversampling factor; OVS = 2^OVS_W (default 16, minimum OVS_W = 1).
- `clk_sys`  in  1  system clock; the only clock.
- `rst_sys`  in  1  asynchronous, active-high reset.
- `en`  in  1  generator enable; level, synchronous.
- `baud_val`  in  DIV_W  integer divisor; tick period base = baud_val+1 cycles.
- `baud_frac`  in  FRAC_W  fractional divisor numerator.
- `rx_resync`  in  1  single-cycle pulse from the receiver's start-bit edge detector.
- `baud_tick`  out  1  oversampling tick, one cycle wide; registered.
- `xmit_pulse`  out  1  one tick in every OVS ticks; transmit bit boundary.
- `rx_sample`  out  1  receive mid-bit sample strobe.

## Operation
- Divider:
  - Down-counter `div_cnt` is DIV_W+1 bits wide, so `baud_val` all-ones plus carry does not overflow.
  - When `div_cnt == 0`, `baud_tick` goes high on the next edge and the counter reloads.
  - On reload, the fractional accumulator updates as {carry, acc} = acc + baud_frac, where acc is FRAC_W bits. The counter reloads with baud_val + carry.
  - Otherwise `div_cnt` decrements and `baud_tick` is 0.
  - Resulting tick period is baud_val+1 cycles, or baud_val+2 on a carry. Average period is baud_val + 1 + baud_frac/2^FRAC_W.
- Configuration sampling:
  - `baud_val` and `baud_frac` are sampled only at reload.
  - A change mid-period does not affect the period in progress, so no short or glitched tick is produced.
- Transmit counter:
  - `tx_cnt` (OVS_W bits) increments on every tick and wraps naturally.
  - `xmit_pulse` = baud_tick & (tx_cnt == OVS-1), decoded from registered state.
- Receive counter:
  - `rx_cnt` (OVS_W bits) increments on every tick.
  - `rx_sample` = baud_tick & (rx_cnt == OVS/2-1) & ~rx_resync.
  - `rx_resync` clears `rx_cnt` to 0 on the next edge and takes priority over a coincident tick; that tick is not counted and `rx_sample` is suppressed.
  - `rx_resync` does not affect the divider or `tx_cnt`.
- `en` = 0:
  - On the next edge, `div_cnt`, acc, `tx_cnt`, `rx_cnt` and `baud_tick` clear to 0.
  - All outputs read 0 while disabled.
  - Re-enabling behaves exactly as leaving reset.
- Reset:
  - `rst_sys` high asynchronously clears all state, independent of the clock.
  - Reset values: `baud_tick` = 0, `xmit_pulse` = 0, `rx_sample` = 0; all counters and acc = 0.
  - Reset asserted mid-period abandons the period; no pending pulse is emitted after release.

## Timing
- The first `baud_tick` is high in the cycle after the first `clk_sys` edge with `en` = 1, because `div_cnt` is 0 out of reset.
- `baud_tick` is always exactly one cycle wide, including at `baud_val` = 0 / `baud_frac` = 0. In that case it stays high continuously, one tick per cycle.
- `xmit_pulse` and `rx_sample` are coincident with the qualifying `baud_tick` cycle; there is no extra latency.
- First `xmit_pulse` after enable: the OVS-th tick. After that, every OVS ticks.
- First `rx_sample` after enable or resync: the (OVS/2)-th counted tick. After that, every OVS ticks.
- Latency of `en` deassert to outputs low: one edge.
- Latency of reset assert to outputs low: combinational/asynchronous.

## Test plan
- Reset and enable, defaults, `baud_val` = 3, `baud_frac` = 0: all outputs 0 during `rst_sys`. After release and `en` = 1, expect:
  - `baud_tick` first high in cycle 1, then every 4 cycles.
  - `xmit_pulse` on the 16th tick and every 64 cycles thereafter.
  - `rx_sample` on the 8th tick.
- Fractional, `baud_val` = 4, `baud_frac` = 8: tick periods alternate 5,6,5,6; 32 ticks span exactly 176 cycles.
- Minimum divisor, `baud_val` = 0, `baud_frac` = 0: `baud_tick` high every cycle; `xmit_pulse` high 1 cycle in 16.
- Resync:
  - `rx_resync` pulsed between ticks: `rx_sample` on the 8th following tick, then every 16 ticks; `xmit_pulse` cadence unchanged.
  - `rx_resync` pulsed in a tick cycle: no `rx_sample` that cycle; count restarts from 0.
- Reconfiguration and enable:
  - `baud_val` changed 3→9 mid-period: the current 4-cycle period completes, then the period becomes 10.
  - `en` dropped mid-period: outputs 0 next edge; on re-enable, tick in the first cycle as after reset.
- Limits and reset:
  - `baud_val` = 2^DIV_W-1 with `baud_frac` = 2^FRAC_W-1: periods of 2^DIV_W or 2^DIV_W+1 cycles, with no wrap to a short period.
  - `rst_sys` pulsed between clock edges: outputs 0 immediately.
